// File: rtl/axi_bus_pkg.sv
// Shared types and constants for the two-master AXI bus mux.
package axi_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRESP = 3'd3,
    ST_RADDR = 3'd4,
    ST_RDATA = 3'd5
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Only a clean one-hot grant may start a transaction.
  function automatic logic gnt_valid(input logic [1:0] g);
    return (g == 2'b01) || (g == 2'b10);
  endfunction

  function automatic logic resp_is_err(input logic [1:0] r);
    return (r == SLVERR) || (r == DECERR);
  endfunction

  function automatic logic resp_is_ok(input logic [1:0] r);
    return (r == OKAY) || (r == EXOKAY);
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Burst beat counter: loads LEN, counts down per handshake, flags the final beat.
module axi_beat_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_last_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  // Holding at zero keeps a stray extra handshake from wrapping to 2^LEN_W-1.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                          cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign is_last_o = (cnt_q == '0);

endmodule

// File: rtl/axi_bus_mux_2to1.sv
// Routes the granted master's write or read channels to the slave for one burst,
// then pulses txn_done so the upstream arbiter can re-arbitrate.
module axi_bus_mux_2to1
  import axi_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          gnt,
  // master side
  input  logic [1:0]          m_awvalid,
  output logic [1:0]          m_awready,
  input  logic [2*ADDR_W-1:0] m_awaddr,
  input  logic [2*LEN_W-1:0]  m_awlen,
  input  logic [1:0]          m_wvalid,
  input  logic [1:0]          m_wlast,
  output logic [1:0]          m_wready,
  input  logic [2*DATA_W-1:0] m_wdata,
  output logic [1:0]          m_bvalid,
  input  logic [1:0]          m_bready,
  output logic [3:0]          m_bresp,
  input  logic [1:0]          m_arvalid,
  output logic [1:0]          m_arready,
  input  logic [2*ADDR_W-1:0] m_araddr,
  input  logic [2*LEN_W-1:0]  m_arlen,
  output logic [1:0]          m_rvalid,
  output logic [1:0]          m_rlast,
  input  logic [1:0]          m_rready,
  output logic [2*DATA_W-1:0] m_rdata,
  output logic [3:0]          m_rresp,
  // slave side
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [LEN_W-1:0]    s_awlen,
  output logic                s_wvalid,
  output logic                s_wlast,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [LEN_W-1:0]    s_arlen,
  input  logic                s_rvalid,
  input  logic                s_rlast,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  // status
  output logic                txn_done,
  output logic [1:0]          txn_resp,
  output logic                err_wlast
);

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   err_q, err_d;
  logic   cnt_load, cnt_dec, cnt_last;
  logic   nsel;

  // Selected-master views; only meaningful outside IDLE.
  logic [ADDR_W-1:0] sm_awaddr, sm_araddr;
  logic [LEN_W-1:0]  sm_awlen, sm_arlen;
  logic [DATA_W-1:0] sm_wdata;

  assign sm_awaddr = sel_q ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
  assign sm_araddr = sel_q ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
  assign sm_awlen  = sel_q ? m_awlen[2*LEN_W-1:LEN_W]    : m_awlen[LEN_W-1:0];
  assign sm_arlen  = sel_q ? m_arlen[2*LEN_W-1:LEN_W]    : m_arlen[LEN_W-1:0];
  assign sm_wdata  = sel_q ? m_wdata[2*DATA_W-1:DATA_W]  : m_wdata[DATA_W-1:0];
  assign nsel      = gnt[1] ? M1 : M0;

  axi_beat_counter #(.LEN_W(LEN_W)) u_wcnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (sm_awlen),
    .dec_i      (cnt_dec),
    .is_last_o  (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    err_d     = err_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_wdata   = '0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_rready  = 1'b0;
    txn_done  = 1'b0;
    txn_resp  = OKAY;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid(gnt)) begin
          if (m_awvalid[nsel]) begin
            sel_d   = nsel;
            state_d = ST_WADDR;
          end else if (m_arvalid[nsel]) begin
            sel_d   = nsel;
            state_d = ST_RADDR;
          end
        end
      end
      ST_WADDR: begin
        s_awvalid        = m_awvalid[sel_q];
        s_awaddr         = sm_awaddr;
        s_awlen          = sm_awlen;
        m_awready[sel_q] = s_awready;
        if (s_awvalid && s_awready) begin
          cnt_load = 1'b1;
          state_d  = ST_WDATA;
        end
      end
      ST_WDATA: begin
        s_wvalid        = m_wvalid[sel_q];
        s_wdata         = sm_wdata;
        s_wlast         = cnt_last;
        m_wready[sel_q] = s_wready;
        if (s_wvalid && s_wready) begin
          cnt_dec = 1'b1;
          if (m_wlast[sel_q] != cnt_last) err_d = 1'b1;
          if (cnt_last) state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        m_bvalid[sel_q]            = s_bvalid;
        m_bresp[{sel_q, 1'b0} +: 2] = s_bresp;
        s_bready                   = m_bready[sel_q];
        if (s_bvalid && s_bready) begin
          txn_done = 1'b1;
          txn_resp = s_bresp;
          state_d  = ST_IDLE;
        end
      end
      ST_RADDR: begin
        s_arvalid        = m_arvalid[sel_q];
        s_araddr         = sm_araddr;
        s_arlen          = sm_arlen;
        m_arready[sel_q] = s_arready;
        if (s_arvalid && s_arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        m_rvalid[sel_q]             = s_rvalid;
        m_rlast[sel_q]              = s_rlast;
        m_rresp[{sel_q, 1'b0} +: 2] = s_rresp;
        m_rdata  = sel_q ? {s_rdata, {DATA_W{1'b0}}} : {{DATA_W{1'b0}}, s_rdata};
        s_rready = m_rready[sel_q];
        if (s_rvalid && s_rready && s_rlast) begin
          txn_done = 1'b1;
          txn_resp = s_rresp;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= M0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign err_wlast = err_q;

endmodule

// File: tb/tb_axi_bus_mux_2to1.sv
// Directed bench for axi_bus_mux_2to1: inputs change on negedge, outputs checked 1ns later.
module tb_axi_bus_mux_2to1;
  localparam int AW = 32, DW = 32, LW = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] gnt = '0;
  logic [1:0] m_awvalid = '0, m_wvalid = '0, m_wlast = '0, m_bready = '0, m_arvalid = '0, m_rready = '0;
  logic [2*AW-1:0] m_awaddr = '0, m_araddr = '0;
  logic [2*LW-1:0] m_awlen = '0, m_arlen = '0;
  logic [2*DW-1:0] m_wdata = '0;
  logic s_awready = 0, s_wready = 0, s_bvalid = 0, s_arready = 0, s_rvalid = 0, s_rlast = 0;
  logic [1:0] s_bresp = '0, s_rresp = '0;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0] m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast, txn_resp;
  logic [3:0] m_bresp, m_rresp;
  logic [2*DW-1:0] m_rdata;
  logic s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready, txn_done, err_wlast;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [LW-1:0] s_awlen, s_arlen;
  logic [DW-1:0] s_wdata;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  axi_bus_mux_2to1 #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .gnt(gnt),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .txn_done(txn_done), .txn_resp(txn_resp), .err_wlast(err_wlast)
  );

  // Every DUT output except err_wlast, for "all quiet" checks.
  wire [255:0] all_out = {m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rlast,
                          m_rdata, m_rresp, s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wlast,
                          s_wdata, s_bready, s_arvalid, s_araddr, s_arlen, s_rready, txn_done, txn_resp};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    gnt = '0; m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_araddr = '0; m_awlen = '0; m_arlen = '0; m_wdata = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0; s_rlast = 0;
    s_bresp = '0; s_rresp = '0; s_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    checks++; if (err_wlast !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_wlast); end
  endtask

  task automatic test_write_single();
    tick();
    gnt = 2'b01; m_awvalid = 2'b01; m_awaddr[AW-1:0] = 32'h100; m_awlen = '0; s_awready = 1; #1;
    checks++; if (s_awvalid !== 1'b0) begin errors++; $display("FAIL ws_idle_awvalid got=%b exp=0", s_awvalid); end
    tick(); #1;
    checks++; if ({s_awvalid, s_awaddr, s_awlen, m_awready} !== {1'b1, 32'h100, 8'h0, 2'b01})
      begin errors++; $display("FAIL ws_aw got=%b/%h/%h/%b exp=1/100/0/01", s_awvalid, s_awaddr, s_awlen, m_awready); end
    tick();
    m_awvalid = '0; gnt = '0; m_wvalid = 2'b01; m_wlast = 2'b01; m_wdata[DW-1:0] = 32'hDEAD0001; s_wready = 1; #1;
    checks++; if ({s_wvalid, s_wlast, s_wdata, m_wready} !== {1'b1, 1'b1, 32'hDEAD0001, 2'b01})
      begin errors++; $display("FAIL ws_w got=%b/%b/%h/%b exp=1/1/dead0001/01", s_wvalid, s_wlast, s_wdata, m_wready); end
    tick();
    m_wvalid = '0; m_wlast = '0; s_bvalid = 1; s_bresp = 2'b00; m_bready = 2'b01; #1;
    checks++; if ({m_bvalid, s_bready, txn_done, txn_resp} !== {2'b01, 1'b1, 1'b1, 2'b00})
      begin errors++; $display("FAIL ws_b got=%b/%b/%b/%b exp=01/1/1/00", m_bvalid, s_bready, txn_done, txn_resp); end
    tick();
    s_bvalid = 0; m_bready = '0; #1;
    checks++; if (txn_done !== 1'b0) begin errors++; $display("FAIL ws_done_pulse got=%b exp=0", txn_done); end
    clr_inputs();
  endtask

  task automatic test_read_burst();
    int dones = 0;
    tick();
    gnt = 2'b10; m_arvalid = 2'b10; m_araddr[2*AW-1:AW] = 32'h2000; m_arlen[2*LW-1:LW] = 8'd3; s_arready = 1;
    tick(); #1;
    checks++; if ({s_arvalid, s_araddr, s_arlen, m_arready} !== {1'b1, 32'h2000, 8'd3, 2'b10})
      begin errors++; $display("FAIL rb_ar got=%b/%h/%h/%b exp=1/2000/3/10", s_arvalid, s_araddr, s_arlen, m_arready); end
    tick();
    m_arvalid = '0; gnt = '0; m_rready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1; s_rdata = 32'hA0 + i; s_rlast = (i == 3); s_rresp = 2'b10; #1;
      checks++;
      if ({m_rvalid, m_rlast, m_rdata, m_rresp[1:0], s_rready} !== {2'b10, (i == 3) ? 2'b10 : 2'b00, 32'hA0 + i, 32'h0, 2'b00, 1'b1})
        begin errors++; $display("FAIL rb_beat%0d got=%b/%b/%h exp=10/%b/%h", i, m_rvalid, m_rlast, m_rdata, (i == 3) ? 2'b10 : 2'b00, {32'hA0 + i, 32'h0}); end
      if (txn_done) begin
        dones++;
        checks++; if (txn_resp !== 2'b10) begin errors++; $display("FAIL rb_resp got=%b exp=10", txn_resp); end
      end
      checks++; if (txn_done !== (i == 3)) begin errors++; $display("FAIL rb_done%0d got=%b exp=%b", i, txn_done, (i == 3)); end
      tick();
    end
    s_rvalid = 0; s_rlast = 0; m_rready = '0; #1;
    checks++; if (dones !== 1) begin errors++; $display("FAIL rb_done_count got=%0d exp=1", dones); end
    checks++; if (all_out !== '0) begin errors++; $display("FAIL rb_idle got=%h exp=0", all_out); end
    clr_inputs();
  endtask

  task automatic test_write_priority();
    tick();
    gnt = 2'b01; m_awvalid = 2'b01; m_arvalid = 2'b01; m_awlen = '0; s_awready = 1; s_arready = 1;
    tick(); #1;
    checks++; if ({s_awvalid, s_arvalid} !== 2'b10) begin errors++; $display("FAIL pr_waddr got=%b exp=10", {s_awvalid, s_arvalid}); end
    tick();
    m_awvalid = '0; m_wvalid = 2'b01; m_wlast = 2'b01; s_wready = 1; #1;
    checks++; if ({s_wvalid, s_arvalid} !== 2'b10) begin errors++; $display("FAIL pr_wdata got=%b exp=10", {s_wvalid, s_arvalid}); end
    tick();
    m_wvalid = '0; m_wlast = '0; s_bvalid = 1; m_bready = 2'b01; #1;
    checks++; if ({txn_done, s_arvalid} !== 2'b10) begin errors++; $display("FAIL pr_wresp got=%b exp=10", {txn_done, s_arvalid}); end
    tick();
    s_bvalid = 0; m_bready = '0; #1;
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL pr_idle_ar got=%b exp=0", s_arvalid); end
    tick(); #1;
    checks++; if ({s_arvalid, m_arready} !== 3'b101) begin errors++; $display("FAIL pr_raddr got=%b/%b exp=1/01", s_arvalid, m_arready); end
    tick();
    m_arvalid = '0; m_rready = 2'b01; s_rvalid = 1; s_rlast = 1; s_rresp = 2'b01; #1;
    checks++; if ({m_rvalid, txn_done, txn_resp} !== {2'b01, 1'b1, 2'b01})
      begin errors++; $display("FAIL pr_read got=%b/%b/%b exp=01/1/01", m_rvalid, txn_done, txn_resp); end
    tick();
    clr_inputs();
  endtask

  task automatic test_wlast_err();
    tick();
    gnt = 2'b01; m_awvalid = 2'b01; m_awlen[LW-1:0] = 8'd2; s_awready = 1;
    tick(); tick();
    m_awvalid = '0; m_wvalid = 2'b01; s_wready = 1;
    for (int i = 0; i < 3; i++) begin
      m_wlast = (i == 1) ? 2'b01 : 2'b00; #1;
      checks++; if ({s_wlast, err_wlast} !== {(i == 2), (i >= 2)})
        begin errors++; $display("FAIL we_beat%0d got wlast/err=%b/%b exp=%b/%b", i, s_wlast, err_wlast, (i == 2), (i >= 2)); end
      tick();
    end
    m_wvalid = '0; m_wlast = '0; s_bvalid = 1; s_bresp = 2'b11; m_bready = 2'b01; #1;
    checks++; if ({txn_done, txn_resp, err_wlast} !== 4'b1111)
      begin errors++; $display("FAIL we_done got=%b/%b/%b exp=1/11/1", txn_done, txn_resp, err_wlast); end
    tick();
    clr_inputs(); #1;
    checks++; if (err_wlast !== 1'b1) begin errors++; $display("FAIL we_sticky got=%b exp=1", err_wlast); end
  endtask

  task automatic test_idle_and_reset();
    tick();
    m_awvalid = 2'b11; m_arvalid = 2'b11; s_awready = 1; s_arready = 1;
    gnt = 2'b11; tick(); #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL ig_gnt11 got=%h exp=0", all_out); end
    gnt = 2'b00; tick(); #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL ig_gnt00 got=%h exp=0", all_out); end
    m_arvalid = '0; gnt = 2'b01; m_awlen[LW-1:0] = 8'd3;
    tick(); tick();
    m_awvalid = '0; m_wvalid = 2'b01; s_wready = 1; #1;
    checks++; if (s_wvalid !== 1'b1) begin errors++; $display("FAIL ig_in_wdata got=%b exp=1", s_wvalid); end
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    gnt = '0; s_bvalid = 1; s_rvalid = 1; s_rlast = 1; m_bready = 2'b11; m_rready = 2'b11; #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL ig_rst_outputs got=%h exp=0", all_out); end
    checks++; if (err_wlast !== 1'b0) begin errors++; $display("FAIL ig_rst_err got=%b exp=0", err_wlast); end
    tick();
    clr_inputs();
  endtask

  task automatic test_gnt_toggle();
    tick();
    gnt = 2'b01; m_awvalid = 2'b01; m_awlen = {8'd1, 8'd7}; s_awready = 1;
    tick(); tick();
    gnt = 2'b10; m_awvalid = 2'b10; m_wvalid = 2'b11; s_wready = 1;
    for (int i = 0; i < 8; i++) begin
      m_wdata = {32'hBBBB0000 + i, 32'hAAAA0000 + i}; m_wlast = (i == 7) ? 2'b11 : 2'b00; #1;
      checks++; if ({s_wdata, m_wready, s_wlast, s_awvalid} !== {32'hAAAA0000 + i, 2'b01, (i == 7), 1'b0})
        begin errors++; $display("FAIL gt_beat%0d got=%h/%b/%b exp=%h/01/%b", i, s_wdata, m_wready, s_wlast, 32'hAAAA0000 + i, (i == 7)); end
      tick();
    end
    m_wvalid = '0; m_wlast = '0; m_awvalid = '0; s_bvalid = 1; s_bresp = 2'b00; m_bready = 2'b11; #1;
    checks++; if ({m_bvalid, txn_done} !== 3'b011) begin errors++; $display("FAIL gt_b got=%b/%b exp=01/1", m_bvalid, txn_done); end
    tick();
    clr_inputs();
  endtask

  task automatic test_len255();
    int lasts = 0, done_at = -1;
    tick();
    gnt = 2'b10; m_awvalid = 2'b10; m_awlen[2*LW-1:LW] = 8'd255; s_awready = 1;
    tick(); tick();
    m_awvalid = '0; gnt = '0; m_wvalid = 2'b10; s_wready = 1;
    for (int i = 0; i < 256; i++) begin
      m_wlast = (i == 255) ? 2'b10 : 2'b00; #1;
      if (s_wlast) lasts++;
      if (i == 255) begin
        checks++; if ({s_wvalid, s_wlast, m_wready} !== 4'b1110)
          begin errors++; $display("FAIL l255_last got=%b/%b/%b exp=1/1/10", s_wvalid, s_wlast, m_wready); end
      end
      tick();
    end
    m_wvalid = '0; m_wlast = '0; s_bvalid = 1; m_bready = 2'b10; #1;
    if (txn_done) done_at = 256;
    checks++; if (lasts !== 1) begin errors++; $display("FAIL l255_wlast_count got=%0d exp=1", lasts); end
    checks++; if ({done_at, m_bvalid} !== {32'd256, 2'b10}) begin errors++; $display("FAIL l255_done got=%0d/%b exp=256/10", done_at, m_bvalid); end
    checks++; if (err_wlast !== 1'b0) begin errors++; $display("FAIL l255_err got=%b exp=0", err_wlast); end
    tick();
    clr_inputs();
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_burst();
    test_write_priority();
    test_wlast_err();
    test_idle_and_reset();
    test_gnt_toggle();
    test_len255();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
